// File: rtl/fb_plot_sink.sv
// 160x120x3 framebuffer sink for the drawing engines' plot bus, with a clear sequencer,
// registered readback and saturating plot statistics. Define FB_PLOT_XOR_EN for XOR plotting.
module fb_plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       vga_x,
  input  logic [6:0]       vga_y,
  input  logic [2:0]       vga_colour,
  input  logic             vga_plot,
  input  logic             clear_start,
  input  logic [2:0]       clear_colour,
  output logic             clear_done,
  output logic             busy,
  input  logic [7:0]       rd_x,
  input  logic [6:0]       rd_y,
  output logic [2:0]       rd_colour,
  output logic [CNT_W-1:0] plot_count,
  output logic [CNT_W-1:0] reject_count
);
  localparam int              DEPTH   = WIDTH * HEIGHT;
  localparam logic [7:0]      W_X     = 8'(WIDTH);
  localparam logic [6:0]      H_Y     = 7'(HEIGHT);
  localparam logic [14:0]     W_A     = 15'(WIDTH);
  localparam logic [14:0]     LAST_A  = 15'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [2:0]       r_mem [0:DEPTH-1];
  logic [14:0]      r_sweep;
  logic [2:0]       r_clr_colour;
  logic [2:0]       r_rd_colour;
  logic [CNT_W-1:0] r_plot_cnt;
  logic [CNT_W-1:0] r_rej_cnt;

  logic        w_plot_on, w_rd_on, w_in_clear, w_accept, w_reject;
  logic [14:0] w_plot_addr, w_rd_addr;
  logic        w_we, w_sweep_we;
  logic [14:0] w_waddr;
  logic [2:0]  w_wdata;

  assign w_plot_on   = (vga_x < W_X) && (vga_y < H_Y);
  assign w_rd_on     = (rd_x < W_X) && (rd_y < H_Y);
  assign w_plot_addr = {8'd0, vga_y} * W_A + {7'd0, vga_x};
  assign w_rd_addr   = {8'd0, rd_y} * W_A + {7'd0, rd_x};
  assign w_in_clear  = (r_state == S_CLEAR);
  assign w_accept    = vga_plot && w_plot_on && !w_in_clear;
  assign w_reject    = vga_plot && !(w_plot_on && !w_in_clear);

`ifdef FB_PLOT_XOR_EN
  logic        r_rmw_vld;
  logic [14:0] r_rmw_addr;
  logic [2:0]  r_rmw_colour;
  logic [2:0]  r_rmw_old;
  logic [2:0]  w_rmw_wdata;

  assign w_rmw_wdata = r_rmw_old ^ r_rmw_colour;

  // Stage 1 reads the old pixel; a same-address plot one cycle behind takes the in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rmw_vld    <= 1'b0;
      r_rmw_addr   <= '0;
      r_rmw_colour <= '0;
      r_rmw_old    <= '0;
    end else begin
      r_rmw_vld <= w_accept;
      if (w_accept) begin
        r_rmw_addr   <= w_plot_addr;
        r_rmw_colour <= vga_colour;
        r_rmw_old    <= (r_rmw_vld && (r_rmw_addr == w_plot_addr)) ? w_rmw_wdata
                                                                   : r_mem[w_plot_addr];
      end
    end
  end

  // A pending RMW write owns the port; the sweep stalls, so DONE is reached only once drained.
  assign w_sweep_we = w_in_clear && !r_rmw_vld;
  assign w_we       = r_rmw_vld || w_sweep_we;
  assign w_waddr    = r_rmw_vld ? r_rmw_addr : r_sweep;
  assign w_wdata    = r_rmw_vld ? w_rmw_wdata : r_clr_colour;
`else
  assign w_sweep_we = w_in_clear;
  assign w_we       = w_accept || w_sweep_we;
  assign w_waddr    = w_in_clear ? r_sweep : w_plot_addr;
  assign w_wdata    = w_in_clear ? r_clr_colour : vga_colour;
`endif

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_colour <= '0;
    else if (w_rd_on) r_rd_colour <= r_mem[w_rd_addr];
    else r_rd_colour <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sweep      <= '0;
      r_clr_colour <= '0;
      r_plot_cnt   <= '0;
      r_rej_cnt    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && clear_start) begin
        r_sweep      <= '0;
        r_clr_colour <= clear_colour;
      end else if (w_sweep_we) begin
        r_sweep <= r_sweep + 15'd1;
      end
      if (w_accept && r_plot_cnt != '1) r_plot_cnt <= r_plot_cnt + CNT_ONE;
      if (w_reject && r_rej_cnt != '1) r_rej_cnt <= r_rej_cnt + CNT_ONE;
    end
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    clear_done   = 1'b0;
    case (r_state)
      S_IDLE: if (clear_start) w_state_next = S_CLEAR;
      S_CLEAR: begin
        busy = 1'b1;
        if (w_sweep_we && r_sweep == LAST_A) w_state_next = S_DONE;
      end
      S_DONE: begin
        clear_done = 1'b1;
        if (!clear_start) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign rd_colour    = r_rd_colour;
  assign plot_count   = r_plot_cnt;
  assign reject_count = r_rej_cnt;
endmodule

// File: tb/tb_fb_plot_sink.sv
// Directed + randomized bench for fb_plot_sink against a pixel-array reference model.
module tb_fb_plot_sink;
  localparam int WIDTH = 160, HEIGHT = 120, CNT_W = 16, DEPTH = WIDTH * HEIGHT;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] vga_x = '0;
  logic [6:0] vga_y = '0;
  logic [2:0] vga_colour = '0;
  logic vga_plot = 1'b0;
  logic clear_start = 1'b0;
  logic [2:0] clear_colour = '0;
  logic clear_done, busy;
  logic [7:0] rd_x = '0;
  logic [6:0] rd_y = '0;
  logic [2:0] rd_colour;
  logic [CNT_W-1:0] plot_count, reject_count;

  always #5 clk = ~clk;

  fb_plot_sink #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_done(clear_done), .busy(busy), .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
    .plot_count(plot_count), .reject_count(reject_count)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] model [0:DEPTH-1];
  int m_plot = 0;
  int m_rej = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit on_screen(input int x, input int y);
    return (x < WIDTH) && (y < HEIGHT);
  endfunction

  function automatic logic [2:0] model_read(input int x, input int y);
    return on_screen(x, y) ? model[y * WIDTH + x] : 3'b000;
  endfunction

  task automatic model_plot(input int x, input int y, input logic [2:0] c, input bit clearing);
    if (!on_screen(x, y) || clearing) begin
      if (m_rej < CNT_MAX) m_rej++;
    end else begin
`ifdef FB_PLOT_XOR_EN
      model[y * WIDTH + x] = model[y * WIDTH + x] ^ c;
`else
      model[y * WIDTH + x] = c;
`endif
      if (m_plot < CNT_MAX) m_plot++;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_plot_cnt"}, 32'(plot_count), m_plot);
    check({tag, "_rej_cnt"}, 32'(reject_count), m_rej);
  endtask

  task automatic do_plot(input int x, input int y, input logic [2:0] c);
    vga_x = 8'(x); vga_y = 7'(y); vga_colour = c; vga_plot = 1'b1;
    model_plot(x, y, c, 1'b0);
    tick();
    vga_plot = 1'b0;
    check_counts("plot");
  endtask

  task automatic check_read(input string tag, input int x, input int y);
    rd_x = 8'(x); rd_y = 7'(y);
    tick();
    check(tag, 32'(rd_colour), 32'(model_read(x, y)));
  endtask

  // Counts busy cycles; optionally plots (5,5) mid-sweep and/or drops clear_start early.
  task automatic run_clear(input logic [2:0] col, input int plot_at, input int drop_at);
    int n;
    n = 0;
    clear_colour = col; clear_start = 1'b1;
    tick();
    while (busy === 1'b1 && n < 20000) begin
      n++;
      vga_plot = 1'b0;
      if (n == plot_at) begin
        vga_x = 8'd5; vga_y = 7'd5; vga_colour = ~col; vga_plot = 1'b1;
        model_plot(5, 5, ~col, 1'b1);
      end
      if (n == drop_at) clear_start = 1'b0;
      tick();
    end
    vga_plot = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = col;
    check("clear_len", n, DEPTH);
    check("clear_done_set", 32'(clear_done), 1);
    check_counts("clear");
    if (clear_start) begin
      tick();
      check("clear_done_held", 32'(clear_done), 1);
      clear_start = 1'b0;
    end
    tick();
    check("clear_done_drop", 32'(clear_done), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  task automatic random_phase();
    int x, y;
    logic [2:0] c;
    bit p;
    for (int i = 0; i < 200; i++) begin
      x = $urandom_range(0, 175); y = $urandom_range(0, 127);
      c = 3'($urandom); p = ($urandom_range(0, 3) != 0);
      vga_x = 8'(x); vga_y = 7'(y); vga_colour = c; vga_plot = p;
      if (p) model_plot(x, y, c, 1'b0);
      tick();
      check_counts("rnd");
    end
    vga_plot = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 120; i++) begin
      x = $urandom_range(0, 170); y = $urandom_range(0, 125);
      check_read("rnd_read", x, y);
    end
  endtask

  initial begin
    int n;
    logic [2:0] old_px;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(clear_done), 0);
    check("rst_rd", 32'(rd_colour), 0);
    check_counts("rst");
    rst_n = 1'b1;
    tick();

    run_clear(3'b010, 0, 0);
    check_read("rd_0_0", 0, 0);
    check_read("rd_159_119", 159, 119);
    check_read("rd_80_60", 80, 60);

    // Plot and read the same pixel on one edge: old data comes back.
    rd_x = 8'd10; rd_y = 7'd20;
    old_px = model_read(10, 20);
    do_plot(10, 20, 3'b111);
    check("rd_before_write", 32'(rd_colour), 32'(old_px));
    tick();
`ifndef FB_PLOT_XOR_EN
    check("rd_after_write", 32'(rd_colour), 32'(model_read(10, 20)));
`endif
    tick();
    check("rd_settled", 32'(rd_colour), 32'(model_read(10, 20)));

    do_plot(160, 0, 3'b101);
    do_plot(0, 120, 3'b101);
    do_plot(255, 127, 3'b101);
    check("offscreen_rej3", 32'(reject_count), 3);
    tick(); tick();
    check_read("rd_10_20_kept", 10, 20);
    check_read("rd_0_0_kept", 0, 0);
    check_read("rd_offscreen", 160, 0);
    check_read("rd_boundary", 159, 119);

    random_phase();

    run_clear(3'b110, 50, 9000);
    check_read("rd_5_5_cleared", 5, 5);

    clear_colour = 3'b001; clear_start = 1'b1;
    tick();
    n = 0;
    while (busy === 1'b1 && n < 100) begin n++; tick(); end
    check("pre_rst_sweep", n, 100);
    #2 rst_n = 1'b0;
    #1;
    m_plot = 0; m_rej = 0;
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(clear_done), 0);
    check("arst_rd", 32'(rd_colour), 0);
    check_counts("arst");
    clear_start = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_clear(3'b100, 0, 0);
    check_read("rd_after_reclear", 80, 60);

`ifdef FB_PLOT_XOR_EN
    run_clear(3'b011, 0, 0);
    vga_x = 8'd7; vga_y = 7'd7; vga_colour = 3'b101; vga_plot = 1'b1;
    model_plot(7, 7, 3'b101, 1'b0);
    tick();
    model_plot(7, 7, 3'b101, 1'b0);
    tick();
    vga_plot = 1'b0;
    tick(); tick();
    check_read("xor_twice", 7, 7);
    check("xor_twice_val", 32'(rd_colour), 3'b011);
    do_plot(7, 7, 3'b101);
    tick(); tick();
    check_read("xor_once", 7, 7);
    check("xor_once_val", 32'(rd_colour), 3'b110);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
